// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : dual-mode VGA timing generator; mode switches on frame wrap.
// Optional colour-bar test pattern: define VGA_TIMING_TESTPATTERN_EN.
// Revision: 1.0
// ============================================================================
module vga_timing_gen #(
   parameter int unsigned COUNT_W    = 11,
   parameter int unsigned RGB_W      = 12,
   parameter int unsigned A_H_TOT    = 1056,
   parameter int unsigned A_H_VIS    = 800,
   parameter int unsigned A_HS_START = 840,
   parameter int unsigned A_HS_LEN   = 128,
   parameter int unsigned A_V_TOT    = 628,
   parameter int unsigned A_V_VIS    = 600,
   parameter int unsigned A_VS_START = 601,
   parameter int unsigned A_VS_LEN   = 4,
   parameter bit          A_HS_POL   = 1'b1,
   parameter bit          A_VS_POL   = 1'b1,
   parameter int unsigned B_H_TOT    = 800,
   parameter int unsigned B_H_VIS    = 640,
   parameter int unsigned B_HS_START = 656,
   parameter int unsigned B_HS_LEN   = 96,
   parameter int unsigned B_V_TOT    = 525,
   parameter int unsigned B_V_VIS    = 480,
   parameter int unsigned B_VS_START = 490,
   parameter int unsigned B_VS_LEN   = 2,
   parameter bit          B_HS_POL   = 1'b0,
   parameter bit          B_VS_POL   = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode_sel,
   output logic               mode_active,
   output logic               frame_start,
   output logic [COUNT_W-1:0] vga_out_hcount,
   output logic [COUNT_W-1:0] vga_out_vcount,
   output logic               vga_out_hsync,
   output logic               vga_out_vsync,
   output logic               vga_out_hblnk,
   output logic               vga_out_vblnk,
   output logic [RGB_W-1:0]   vga_out_rgb
);

   localparam int unsigned XW = COUNT_W + 1;
   localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

   // Compare constants carry one extra bit so START+LEN == 2^COUNT_W still fits.
   localparam logic [COUNT_W:0] A_H_LAST = XW'(A_H_TOT - 1);
   localparam logic [COUNT_W:0] A_V_LAST = XW'(A_V_TOT - 1);
   localparam logic [COUNT_W:0] A_HV     = XW'(A_H_VIS);
   localparam logic [COUNT_W:0] A_VV     = XW'(A_V_VIS);
   localparam logic [COUNT_W:0] A_HS_B   = XW'(A_HS_START);
   localparam logic [COUNT_W:0] A_HS_E   = XW'(A_HS_START + A_HS_LEN);
   localparam logic [COUNT_W:0] A_VS_B   = XW'(A_VS_START);
   localparam logic [COUNT_W:0] A_VS_E   = XW'(A_VS_START + A_VS_LEN);
   localparam logic [COUNT_W:0] B_H_LAST = XW'(B_H_TOT - 1);
   localparam logic [COUNT_W:0] B_V_LAST = XW'(B_V_TOT - 1);
   localparam logic [COUNT_W:0] B_HV     = XW'(B_H_VIS);
   localparam logic [COUNT_W:0] B_VV     = XW'(B_V_VIS);
   localparam logic [COUNT_W:0] B_HS_B   = XW'(B_HS_START);
   localparam logic [COUNT_W:0] B_HS_E   = XW'(B_HS_START + B_HS_LEN);
   localparam logic [COUNT_W:0] B_VS_B   = XW'(B_VS_START);
   localparam logic [COUNT_W:0] B_VS_E   = XW'(B_VS_START + B_VS_LEN);

   generate
      if ((RGB_W % 3 != 0) ||
          (64'(A_H_TOT) > (64'd1 << COUNT_W)) || (64'(A_V_TOT) > (64'd1 << COUNT_W)) ||
          (64'(B_H_TOT) > (64'd1 << COUNT_W)) || (64'(B_V_TOT) > (64'd1 << COUNT_W)) ||
          (A_HS_START + A_HS_LEN > A_H_TOT) || (A_VS_START + A_VS_LEN > A_V_TOT) ||
          (B_HS_START + B_HS_LEN > B_H_TOT) || (B_VS_START + B_VS_LEN > B_V_TOT))
      begin : g_param_err
         $error("vga_timing_gen: inconsistent timing parameters");
      end
   endgenerate

   logic [COUNT_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
   logic               mode_q, mode_d;
   logic               hsync_q, hsync_d, vsync_q, vsync_d;
   logic               hblnk_q, hblnk_d, vblnk_q, vblnk_d;
   logic               frame_start_q, frame_start_d;
   logic [COUNT_W:0]   h_ext, v_ext;
   logic               h_last, v_last, hs_win, vs_win;

   // Next position is computed first; all derived signals describe that position
   // under the mode that will govern it, so a switch lands cleanly on (0,0).
   always_comb begin
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      mode_d        = mode_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      hblnk_d       = hblnk_q;
      vblnk_d       = vblnk_q;
      frame_start_d = frame_start_q;
      h_ext         = '0;
      v_ext         = '0;
      hs_win        = 1'b0;
      vs_win        = 1'b0;
      h_last        = ({1'b0, hcount_q} == (mode_q ? B_H_LAST : A_H_LAST));
      v_last        = ({1'b0, vcount_q} == (mode_q ? B_V_LAST : A_V_LAST));
      if (en) begin
         if (h_last) begin
            hcount_d = '0;
            vcount_d = v_last ? '0 : vcount_q + ONE;
         end else begin
            hcount_d = hcount_q + ONE;
         end
         if (h_last && v_last) mode_d = mode_sel;
         h_ext         = {1'b0, hcount_d};
         v_ext         = {1'b0, vcount_d};
         hblnk_d       = (h_ext >= (mode_d ? B_HV : A_HV));
         vblnk_d       = (v_ext >= (mode_d ? B_VV : A_VV));
         hs_win        = (h_ext >= (mode_d ? B_HS_B : A_HS_B)) && (h_ext < (mode_d ? B_HS_E : A_HS_E));
         vs_win        = (v_ext >= (mode_d ? B_VS_B : A_VS_B)) && (v_ext < (mode_d ? B_VS_E : A_VS_E));
         hsync_d       = ~(hs_win ^ (mode_d ? B_HS_POL : A_HS_POL));
         vsync_d       = ~(vs_win ^ (mode_d ? B_VS_POL : A_VS_POL));
         frame_start_d = (hcount_d == '0) && (vcount_d == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         mode_q        <= 1'b0;
         hsync_q       <= ~A_HS_POL;
         vsync_q       <= ~A_VS_POL;
         hblnk_q       <= 1'b0;
         vblnk_q       <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         mode_q        <= mode_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         hblnk_q       <= hblnk_d;
         vblnk_q       <= vblnk_d;
         frame_start_q <= frame_start_d;
      end
   end

`ifdef VGA_TIMING_TESTPATTERN_EN
   localparam int unsigned CH = RGB_W / 3;
   localparam logic [COUNT_W:0] A_BAR_LAST = XW'(((A_H_VIS / 8) > 0 ? (A_H_VIS / 8) : 1) - 1);
   localparam logic [COUNT_W:0] B_BAR_LAST = XW'(((B_H_VIS / 8) > 0 ? (B_H_VIS / 8) : 1) - 1);

   logic [2:0]         bar_q, bar_d;
   logic [COUNT_W-1:0] bar_px_q, bar_px_d;
   logic [RGB_W-1:0]   rgb_q, rgb_d;

   // Bar index in bar_d: bit2 clears green, bit1 clears red, bit0 clears blue.
   always_comb begin
      bar_d    = bar_q;
      bar_px_d = bar_px_q;
      rgb_d    = rgb_q;
      if (en) begin
         if (hcount_d == '0) begin
            bar_d    = '0;
            bar_px_d = '0;
         end else if ({1'b0, bar_px_q} == (mode_d ? B_BAR_LAST : A_BAR_LAST)) begin
            bar_px_d = '0;
            if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
         end else begin
            bar_px_d = bar_px_q + ONE;
         end
         rgb_d = (hblnk_d || vblnk_d) ? '0 :
                 {{CH{~bar_d[1]}}, {CH{~bar_d[2]}}, {CH{~bar_d[0]}}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bar_q    <= '0;
         bar_px_q <= '0;
         rgb_q    <= '0;
      end else begin
         bar_q    <= bar_d;
         bar_px_q <= bar_px_d;
         rgb_q    <= rgb_d;
      end
   end

   assign vga_out_rgb = rgb_q;
`else
   assign vga_out_rgb = '0;
`endif

   assign mode_active    = mode_q;
   assign frame_start    = frame_start_q;
   assign vga_out_hcount = hcount_q;
   assign vga_out_vcount = vcount_q;
   assign vga_out_hsync  = hsync_q;
   assign vga_out_vsync  = vsync_q;
   assign vga_out_hblnk  = hblnk_q;
   assign vga_out_vblnk  = vblnk_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_timing_gen : scaled-timing bench with a linear pixel-index frame model.
// Revision: 1.0
// ============================================================================
module tb_vga_timing_gen;

   localparam int CW = 11;
   localparam int RW = 12;
   // Index map: 0 HTOT,1 HVIS,2 HS_START,3 HS_LEN,4 VTOT,5 VVIS,6 VS_START,7 VS_LEN,8 HPOL,9 VPOL
   localparam int PA [10] = '{40, 32, 34, 4, 12, 8, 9, 2, 1, 1};
   localparam int PB [10] = '{30, 24, 25, 3, 10, 6, 7, 1, 0, 0};
   localparam logic [11:0] COL [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                       12'hF0F, 12'hF00, 12'h00F, 12'h000};

   logic          clk = 1'b0;
   logic          rst, en, mode_sel;
   logic          mode_active, frame_start;
   logic [CW-1:0] hcount, vcount;
   logic          hsync, vsync, hblnk, vblnk;
   logic [RW-1:0] rgb;

   vga_timing_gen #(
      .COUNT_W(CW), .RGB_W(RW),
      .A_H_TOT(PA[0]), .A_H_VIS(PA[1]), .A_HS_START(PA[2]), .A_HS_LEN(PA[3]),
      .A_V_TOT(PA[4]), .A_V_VIS(PA[5]), .A_VS_START(PA[6]), .A_VS_LEN(PA[7]),
      .A_HS_POL(1'b1), .A_VS_POL(1'b1),
      .B_H_TOT(PB[0]), .B_H_VIS(PB[1]), .B_HS_START(PB[2]), .B_HS_LEN(PB[3]),
      .B_V_TOT(PB[4]), .B_V_VIS(PB[5]), .B_VS_START(PB[6]), .B_VS_LEN(PB[7]),
      .B_HS_POL(1'b0), .B_VS_POL(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .mode_sel(mode_sel),
      .mode_active(mode_active), .frame_start(frame_start),
      .vga_out_hcount(hcount), .vga_out_vcount(vcount),
      .vga_out_hsync(hsync), .vga_out_vsync(vsync),
      .vga_out_hblnk(hblnk), .vga_out_vblnk(vblnk),
      .vga_out_rgb(rgb)
   );

   always #5 clk = ~clk;

   wire [39:0] obs = {mode_active, frame_start, hcount, vcount, hsync, vsync, hblnk, vblnk, rgb};

   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_idx;
   logic m_mode, m_fs, m_rgb0;

   function automatic int p(logic m, int k);
      return m ? PB[k] : PA[k];
   endfunction

   function automatic int m_h();
      return m_idx % p(m_mode, 0);
   endfunction

   function automatic int m_v();
      return m_idx / p(m_mode, 0);
   endfunction

   function automatic logic [39:0] model_vec();
      int h, v, k;
      logic hs, vs, hb, vb;
      logic [RW-1:0] c;
      h  = m_h();
      v  = m_v();
      hb = (h >= p(m_mode, 1));
      vb = (v >= p(m_mode, 5));
      hs = (h >= p(m_mode, 2) && h < p(m_mode, 2) + p(m_mode, 3)) ? (p(m_mode, 8) != 0) : (p(m_mode, 8) == 0);
      vs = (v >= p(m_mode, 6) && v < p(m_mode, 6) + p(m_mode, 7)) ? (p(m_mode, 9) != 0) : (p(m_mode, 9) == 0);
      c  = '0;
`ifdef VGA_TIMING_TESTPATTERN_EN
      if (!hb && !vb && !m_rgb0) begin
         k = h / (p(m_mode, 1) / 8);
         if (k > 7) k = 7;
         c = COL[k];
      end
`else
      k = 0;
`endif
      return {m_mode, m_fs, CW'(h), CW'(v), hs, vs, hb, vb, c};
   endfunction

   task automatic model_reset();
      m_idx = 0; m_mode = 1'b0; m_fs = 1'b0; m_rgb0 = 1'b1;
   endtask

   task automatic model_advance(input logic s);
      if (m_idx == p(m_mode, 0) * p(m_mode, 4) - 1) begin
         m_idx  = 0;
         m_mode = s;
      end else begin
         m_idx++;
      end
      m_fs   = (m_idx == 0);
      m_rgb0 = 1'b0;
   endtask

   task automatic step();
      logic e, s, r;
      e = en; s = mode_sel; r = rst;
      @(posedge clk);
      if (!r && e) model_advance(s);
      #1;
   endtask

   task automatic goto_pos(input int h, input int v);
      int n;
      n = 0;
      while (!(m_h() == h && m_v() == v) && n < 3000) begin
         step();
         n++;
      end
      if (n >= 3000) begin
         n_checks++; n_fail++;
         $display("FAIL goto_pos: position (%0d,%0d) not reached within 3000 cycles", h, v);
      end
   endtask

   task automatic test_reset();
      logic [39:0] exp;
      rst = 1'b1; en = 1'b0; mode_sel = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      exp = model_vec();
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL reset_state: got %h expected %h", obs, exp); end
      n_checks++;
      if (obs !== 40'h0) begin n_fail++; $display("FAIL reset_zero: got %h expected %h", obs, 40'h0); end
      rst = 1'b0; en = 1'b1;
      step();
      n_checks++;
      if (hcount !== 11'd1 || vcount !== 11'd0 || frame_start !== 1'b0) begin
         n_fail++; $display("FAIL first_advance: got (%0d,%0d) fs=%b expected (1,0) fs=0", hcount, vcount, frame_start);
      end
   endtask

   task automatic test_deferred_switch();
      logic [39:0] exp;
      int guard;
      goto_pos(10, 3);
      mode_sel = 1'b1;
      guard = 0;
      do begin
         step();
         guard++;
         exp = model_vec();
         n_checks++;
         if (obs !== exp) begin n_fail++; $display("FAIL switch_track: got %h expected %h", obs, exp); end
         if (m_idx != 0) begin
            n_checks++;
            if (mode_active !== 1'b0) begin n_fail++; $display("FAIL switch_early: mode_active=%b expected 0 at (%0d,%0d)", mode_active, hcount, vcount); end
         end
      end while (m_idx != 0 && guard < 1000);
      n_checks++;
      if ({mode_active, frame_start, hcount, vcount} !== {1'b1, 1'b1, 11'd0, 11'd0}) begin
         n_fail++; $display("FAIL switch_boundary: got mode=%b fs=%b (%0d,%0d) expected mode=1 fs=1 (0,0)", mode_active, frame_start, hcount, vcount);
      end
      repeat (29) step();
      n_checks++;
      if (hcount !== 11'd29 || vcount !== 11'd0) begin n_fail++; $display("FAIL switch_line_end: got (%0d,%0d) expected (29,0)", hcount, vcount); end
      step();
      n_checks++;
      if (hcount !== 11'd0 || vcount !== 11'd1 || frame_start !== 1'b0) begin
         n_fail++; $display("FAIL switch_first_wrap: got (%0d,%0d) fs=%b expected (0,1) fs=0", hcount, vcount, frame_start);
      end
   endtask

   task automatic test_line_wrap();
      goto_pos(29, 3);
      n_checks++;
      if (hcount !== 11'd29 || vcount !== 11'd3 || hblnk !== 1'b1) begin
         n_fail++; $display("FAIL wrap_before: got (%0d,%0d) hblnk=%b expected (29,3) hblnk=1", hcount, vcount, hblnk);
      end
      step();
      n_checks++;
      if (hcount !== 11'd0 || vcount !== 11'd4 || hblnk !== 1'b0) begin
         n_fail++; $display("FAIL wrap_after: got (%0d,%0d) hblnk=%b expected (0,4) hblnk=0", hcount, vcount, hblnk);
      end
   endtask

   task automatic test_sync_window();
      logic [39:0] exp;
      int hs_n, vs_n, hs_min, hs_max, vs_min, vs_max, hb_min, vb_min;
      hs_n = 0; vs_n = 0; hs_min = 9999; hs_max = -1; vs_min = 9999; vs_max = -1; hb_min = 9999; vb_min = 9999;
      goto_pos(0, 0);
      for (int i = 0; i < PB[0] * PB[4]; i++) begin
         if (i != 0) step();
         exp = model_vec();
         n_checks++;
         if (obs !== exp) begin n_fail++; $display("FAIL sync_track: got %h expected %h", obs, exp); end
         if (hsync === 1'b0) begin hs_n++; if (int'(hcount) < hs_min) hs_min = int'(hcount); if (int'(hcount) > hs_max) hs_max = int'(hcount); end
         if (vsync === 1'b0) begin vs_n++; if (int'(vcount) < vs_min) vs_min = int'(vcount); if (int'(vcount) > vs_max) vs_max = int'(vcount); end
         if (hblnk === 1'b1 && int'(hcount) < hb_min) hb_min = int'(hcount);
         if (vblnk === 1'b1 && int'(vcount) < vb_min) vb_min = int'(vcount);
      end
      n_checks++;
      if (hs_n != PB[3] * PB[4] || hs_min != PB[2] || hs_max != PB[2] + PB[3] - 1) begin
         n_fail++; $display("FAIL hsync_window: got n=%0d [%0d..%0d] expected n=%0d [%0d..%0d]", hs_n, hs_min, hs_max, PB[3] * PB[4], PB[2], PB[2] + PB[3] - 1);
      end
      n_checks++;
      if (vs_n != PB[7] * PB[0] || vs_min != PB[6] || vs_max != PB[6] + PB[7] - 1) begin
         n_fail++; $display("FAIL vsync_window: got n=%0d [%0d..%0d] expected n=%0d [%0d..%0d]", vs_n, vs_min, vs_max, PB[7] * PB[0], PB[6], PB[6] + PB[7] - 1);
      end
      n_checks++;
      if (hb_min != PB[1] || vb_min != PB[5]) begin
         n_fail++; $display("FAIL blank_edges: got hblnk@%0d vblnk@%0d expected %0d %0d", hb_min, vb_min, PB[1], PB[5]);
      end
   endtask

   task automatic test_enable_hold();
      logic [39:0] snap, exp;
      goto_pos(12, 4);
      snap = obs;
      en = 1'b0;
      repeat (5) begin
         step();
         n_checks++;
         if (obs !== snap) begin n_fail++; $display("FAIL enable_hold: got %h expected %h", obs, snap); end
      end
      en = 1'b1;
      step();
      exp = model_vec();
      n_checks++;
      if (hcount !== 11'd13 || vcount !== 11'd4 || obs !== exp) begin
         n_fail++; $display("FAIL enable_resume: got %h expected %h", obs, exp);
      end
   endtask

   task automatic test_reset_mid();
      logic [39:0] exp;
      goto_pos(20, 5);
      n_checks++;
      if (mode_active !== 1'b1) begin n_fail++; $display("FAIL reset_mid_pre: mode_active=%b expected 1", mode_active); end
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      exp = model_vec();
      n_checks++;
      if (obs !== exp || obs !== 40'h0) begin n_fail++; $display("FAIL reset_async: got %h expected %h", obs, exp); end
      @(posedge clk);
      #1;
      rst = 1'b0; mode_sel = 1'b0;
      step();
      n_checks++;
      if (hcount !== 11'd1 || vcount !== 11'd0 || mode_active !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: got (%0d,%0d) mode=%b expected (1,0) mode=0", hcount, vcount, mode_active);
      end
   endtask

`ifdef VGA_TIMING_TESTPATTERN_EN
   task automatic test_pattern();
      logic [11:0] exp;
      goto_pos(0, 1);
      for (int h = 0; h < PA[0]; h++) begin
         if (h != 0) step();
         exp = (h >= PA[1]) ? 12'h000 : COL[h / (PA[1] / 8)];
         n_checks++;
         if (rgb !== exp) begin n_fail++; $display("FAIL pattern_h%0d: got %h expected %h", h, rgb, exp); end
      end
   endtask
`endif

   task automatic test_random();
      logic [39:0] exp;
      for (int i = 0; i < 4000; i++) begin
         en = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 7) == 0) mode_sel = 1'($urandom_range(0, 1));
         step();
         exp = model_vec();
         n_checks++;
         if (obs !== exp) begin n_fail++; $display("FAIL random_%0d: got %h expected %h", i, obs, exp); end
      end
      en = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_deferred_switch();
      test_line_wrap();
      test_sync_window();
      test_enable_hold();
      test_reset_mid();
`ifdef VGA_TIMING_TESTPATTERN_EN
      test_pattern();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
